// File: rtl/phase_controller.sv
// -----------------------------------------------------------------------------
// phase_controller
//
// Traffic-light phase sequencer. A tick-driven Moore FSM walks through the
// main, left-turn, secondary and pedestrian phases. Each phase has its own
// duration timer, and a latched pedestrian request is kept between phases.
// Lane-comparison flags from the upstream comparator can shorten the green
// phases. The flags never reach the lights combinationally.
//
// Parameters
//   GREEN_MIN  minimum green duration in ticks          (1 <= GREEN_MIN)
//   GREEN_MAX  maximum (extended) green duration, ticks (GREEN_MIN <= GREEN_MAX)
//   YELLOW     yellow duration in ticks                 (>= 1)
//   PED_WALK   pedestrian walk duration in ticks        (>= 1)
//   CNT_W      timer width; every duration must be < 2**CNT_W
//
// Ports
//   clk         single clock; all state updates occur on the rising edge
//   rst_n       asynchronous active-low reset
//   tick        one-cycle time-base enable; nothing advances without it
//   m_more      main queue exceeds twice the left queue
//   l_zero      left queue empty
//   s_more      secondary queue equals main queue
//   p_more      pedestrian count exceeds main plus secondary (sampled every cycle)
//   main_light  main head       {red, yellow, green}, one-hot
//   left_light  left-turn head  {red, yellow, green}, one-hot
//   sec_light   secondary head  {red, yellow, green}, one-hot
//   ped_walk    walk indication, high only in PED
//   phase       current state encoding
//   timer       ticks completed in the current state
// -----------------------------------------------------------------------------
module phase_controller #(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned PED_WALK  = 10,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             m_more,
  input  logic             l_zero,
  input  logic             s_more,
  input  logic             p_more,
  output logic [2:0]       main_light,
  output logic [2:0]       left_light,
  output logic [2:0]       sec_light,
  output logic             ped_walk,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] timer
);

  // ---------------------------------------------------------------------------
  // State encoding. The values are visible on the phase output, so they are fixed.
  // ---------------------------------------------------------------------------
  localparam logic [2:0] MAIN_G  = 3'd0;
  localparam logic [2:0] MAIN_Y  = 3'd1;
  localparam logic [2:0] LEFT_G  = 3'd2;
  localparam logic [2:0] LEFT_Y  = 3'd3;
  localparam logic [2:0] SEC_G   = 3'd4;
  localparam logic [2:0] SEC_Y   = 3'd5;
  localparam logic [2:0] PED     = 3'd6;
  localparam logic [2:0] ALL_RED = 3'd7;

  // Signal-head encodings: {red, yellow, green}.
  localparam logic [2:0] HEAD_RED = 3'b100;
  localparam logic [2:0] HEAD_YEL = 3'b010;
  localparam logic [2:0] HEAD_GRN = 3'b001;

  // Durations converted once to timer width so every compare is width-matched.
  localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] WALK_C = CNT_W'(PED_WALK);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [2:0]       next_ph_q, next_ph_d;     // target of the current ALL_RED
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;

  // Exit decode for the current state
  logic [CNT_W-1:0] ticks_n;                  // ticks completed if this tick counts
  logic             exit_now;                 // current state ends on this tick
  logic [2:0]       exit_to;                  // state entered when it ends
  logic             load_next;                // latch a new ALL_RED target
  logic [2:0]       next_target;
  logic             entering_ped;

  // ---------------------------------------------------------------------------
  // Exit conditions. They are evaluated as if the current cycle carries a tick.
  // The result is used only when tick is high. The timer is bounded by every
  // exit condition, so ticks_n never wraps.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    ticks_n     = timer_q + ONE_C;
    exit_now    = 1'b0;
    exit_to     = state_q;
    load_next   = 1'b0;
    next_target = next_ph_q;

    case (state_q)
      MAIN_G: begin
        exit_now = ((ticks_n >= GMIN_C) && !m_more) || (ticks_n == GMAX_C);
        exit_to  = MAIN_Y;
      end
      LEFT_G: begin
        exit_now = ((ticks_n >= GMIN_C) && l_zero) || (ticks_n == GMAX_C);
        exit_to  = LEFT_Y;
      end
      SEC_G: begin
        exit_now = ((ticks_n >= GMIN_C) && !s_more) || (ticks_n == GMAX_C);
        exit_to  = SEC_Y;
      end
      // Each yellow phase leaves through ALL_RED. It chooses the phase that
      // follows the all-red interval now, from the flags on its exit tick.
      MAIN_Y: begin
        exit_now    = (ticks_n == YEL_C);
        exit_to     = ALL_RED;
        load_next   = 1'b1;
        next_target = l_zero ? SEC_G : LEFT_G;
      end
      LEFT_Y: begin
        exit_now    = (ticks_n == YEL_C);
        exit_to     = ALL_RED;
        load_next   = 1'b1;
        next_target = SEC_G;
      end
      SEC_Y: begin
        exit_now    = (ticks_n == YEL_C);
        exit_to     = ALL_RED;
        load_next   = 1'b1;
        // A request that arrives on this very cycle still counts. It is not
        // yet in ped_pending_q.
        next_target = (ped_pending_q || p_more) ? PED : MAIN_G;
      end
      PED: begin
        exit_now    = (ticks_n == WALK_C);
        exit_to     = ALL_RED;
        load_next   = 1'b1;
        next_target = MAIN_G;
      end
      default: begin // ALL_RED: one tick, then go to the latched target
        exit_now = (ticks_n == ONE_C);
        exit_to  = next_ph_q;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state, timer and pedestrian-request logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    next_ph_d     = next_ph_q;
    ped_pending_d = ped_pending_q;

    if (tick) begin
      if (exit_now) begin
        state_d = exit_to;
        timer_d = '0;
        if (load_next) begin
          next_ph_d = next_target;
        end
      end else begin
        timer_d = ticks_n;
      end
    end

    // The request is consumed on the edge that enters PED. The clear has
    // priority, because a request seen during that same cycle is served by
    // the walk phase that is starting.
    entering_ped = tick && exit_now && (exit_to == PED) && (state_q != PED);
    if (entering_ped) begin
      ped_pending_d = 1'b0;
    end else if (p_more && (state_q != PED)) begin
      ped_pending_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only. All flops then
  // sample the values from before the edge, and simulation matches hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ALL_RED;
      next_ph_q     <= MAIN_G;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_ph_q     <= next_ph_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. The outputs depend only on the state register.
  // Reset forces ALL_RED, so every head goes red as soon as rst_n falls.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_light = HEAD_RED;
    left_light = HEAD_RED;
    sec_light  = HEAD_RED;
    ped_walk   = 1'b0;

    case (state_q)
      MAIN_G:  main_light = HEAD_GRN;
      MAIN_Y:  main_light = HEAD_YEL;
      LEFT_G:  left_light = HEAD_GRN;
      LEFT_Y:  left_light = HEAD_YEL;
      SEC_G:   sec_light  = HEAD_GRN;
      SEC_Y:   sec_light  = HEAD_YEL;
      PED:     ped_walk   = 1'b1;
      default: ; // ALL_RED: every head red
    endcase
  end

  assign phase = state_q;
  assign timer = timer_q;

endmodule

// File: tb/tb_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_phase_controller
//
// Table-driven bench for phase_controller with default parameters. Each vector
// holds the flags for one tick and the phase/timer expected after that tick.
// When a vector is driven, its expectation is queued. The expectation is
// compared with the DUT outputs on the following falling edge. The light
// values are derived from the expected phase by a local decoder. Asynchronous
// reset and the long idle period are written out by hand.
// -----------------------------------------------------------------------------
module tb_phase_controller;

  localparam logic [2:0] MAIN_G  = 3'd0;
  localparam logic [2:0] MAIN_Y  = 3'd1;
  localparam logic [2:0] LEFT_G  = 3'd2;
  localparam logic [2:0] LEFT_Y  = 3'd3;
  localparam logic [2:0] SEC_G   = 3'd4;
  localparam logic [2:0] SEC_Y   = 3'd5;
  localparam logic [2:0] PED     = 3'd6;
  localparam logic [2:0] ALL_RED = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n, tick, m_more, l_zero, s_more, p_more;
  logic [2:0] main_light, left_light, sec_light, phase;
  logic       ped_walk;
  logic [4:0] timer;

  phase_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .m_more     (m_more),
    .l_zero     (l_zero),
    .s_more     (s_more),
    .p_more     (p_more),
    .main_light (main_light),
    .left_light (left_light),
    .sec_light  (sec_light),
    .ped_walk   (ped_walk),
    .phase      (phase),
    .timer      (timer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m, l, s, p;
    logic       pre_p;   // one non-tick cycle with p_more=1 before this tick
    logic [2:0] ph;
    logic [4:0] tmr;
  } vec_t;

  typedef struct {
    logic [2:0] ph;
    logic [4:0] tmr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {main, left, sec, walk} for a phase
  function automatic logic [9:0] lights_of(input logic [2:0] ph);
    case (ph)
      MAIN_G:  return {3'b001, 3'b100, 3'b100, 1'b0};
      MAIN_Y:  return {3'b010, 3'b100, 3'b100, 1'b0};
      LEFT_G:  return {3'b100, 3'b001, 3'b100, 1'b0};
      LEFT_Y:  return {3'b100, 3'b010, 3'b100, 1'b0};
      SEC_G:   return {3'b100, 3'b100, 3'b001, 1'b0};
      SEC_Y:   return {3'b100, 3'b100, 3'b010, 1'b0};
      PED:     return {3'b100, 3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic compare_outputs(input string tag, input exp_t e);
    logic [9:0] l;
    l = lights_of(e.ph);
    check({tag, ".phase"}, phase, e.ph);
    check({tag, ".timer"}, timer, e.tmr);
    check({tag, ".lights"}, {main_light, left_light, sec_light, ped_walk}, l);
  endtask

  task automatic add(input logic [2:0] ph, input int t0, input int t1,
                     input logic m, input logic l, input logic s, input logic p,
                     input logic pre = 1'b0);
    vec_t v;
    for (int t = t0; t <= t1; t++) begin
      v.m = m; v.l = l; v.s = s; v.p = p;
      v.pre_p = pre && (t == t0);
      v.ph = ph;
      v.tmr = 5'(t);
      vecs.push_back(v);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare_outputs($sformatf("%s[%0d]", tag, step), e);
      step++;
    end
  endtask

  // Drive every queued vector, one tick per cycle. Each expectation is
  // checked one falling edge after it is driven.
  task automatic run_vectors(input string tag);
    vec_t v;
    exp_t e;
    step = 0;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      if (v.pre_p) begin
        @(negedge clk);
        drain(tag);
        tick = 1'b0; p_more = 1'b1;
      end
      @(negedge clk);
      drain(tag);
      m_more = v.m; l_zero = v.l; s_more = v.s; p_more = v.p;
      tick = 1'b1;
      e.ph = v.ph; e.tmr = v.tmr;
      sb.push_back(e);
    end
    @(negedge clk);
    drain(tag);
    tick = 1'b0; p_more = 1'b0;
  endtask

  // The default green-to-green cycle returns to MAIN_G with timer 0, here
  // without PED.
  task automatic add_plain_cycle();
    add(MAIN_G, 1, 7, 0, 1, 0, 0);
    add(MAIN_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(SEC_G, 0, 7, 0, 1, 0, 0);
    add(SEC_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(MAIN_G, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    rst_e.ph = ALL_RED; rst_e.tmr = 5'd0;

    rst_n = 1'b0; tick = 1'b0;
    m_more = 1'b0; l_zero = 1'b1; s_more = 1'b0; p_more = 1'b0;
    #12;
    compare_outputs("reset", rst_e);
    @(negedge clk);
    rst_n = 1'b1;

    // Default flags: the full cycle is 24 ticks
    add(MAIN_G, 0, 0, 0, 1, 0, 0);
    add_plain_cycle();
    // m_more held: MAIN_G lasts GREEN_MAX ticks
    add(MAIN_G, 1, 19, 1, 1, 0, 0);
    add(MAIN_Y, 0, 0, 1, 1, 0, 0);
    add(MAIN_Y, 1, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(SEC_G, 0, 0, 0, 1, 0, 0);
    // s_more keeps SEC_G until it drops at the 12th tick
    add(SEC_G, 1, 11, 0, 1, 1, 0);
    add(SEC_Y, 0, 2, 0, 1, 0, 0);
    // p_more present on the SEC_Y exit tick selects PED directly
    add(ALL_RED, 0, 0, 0, 1, 0, 1);
    add(PED, 0, 9, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(MAIN_G, 0, 0, 0, 1, 0, 0);
    // m_more dropped at the 12th tick ends MAIN_G there
    add(MAIN_G, 1, 11, 1, 1, 0, 0);
    add(MAIN_Y, 0, 2, 0, 1, 0, 0);
    // l_zero low on the MAIN_Y exit tick routes to LEFT_G
    add(ALL_RED, 0, 0, 0, 0, 0, 0);
    add(LEFT_G, 0, 4, 0, 0, 0, 0);
    // l_zero raised early still holds green to GREEN_MIN
    add(LEFT_G, 5, 7, 0, 1, 0, 0);
    add(LEFT_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(SEC_G, 0, 7, 0, 1, 0, 0);
    add(SEC_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(MAIN_G, 0, 0, 0, 1, 0, 0);
    // l_zero held low: LEFT_G lasts GREEN_MAX ticks
    add(MAIN_G, 1, 7, 0, 0, 0, 0);
    add(MAIN_Y, 0, 2, 0, 0, 0, 0);
    add(ALL_RED, 0, 0, 0, 0, 0, 0);
    add(LEFT_G, 0, 19, 0, 0, 0, 0);
    add(LEFT_Y, 0, 2, 0, 0, 0, 0);
    add(ALL_RED, 0, 0, 0, 0, 0, 0);
    add(SEC_G, 0, 7, 0, 0, 0, 0);
    add(SEC_Y, 0, 2, 0, 0, 0, 0);
    add(ALL_RED, 0, 0, 0, 0, 0, 0);
    add(MAIN_G, 0, 0, 0, 0, 0, 0);
    // p_more pulsed on a non-tick cycle in MAIN_G: the latched request gives PED
    add(MAIN_G, 1, 3, 0, 1, 0, 0);
    add(MAIN_G, 4, 7, 0, 1, 0, 0, 1'b1);
    add(MAIN_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(SEC_G, 0, 7, 0, 1, 0, 0);
    add(SEC_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(PED, 0, 9, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 1, 0, 0);
    add(MAIN_G, 0, 0, 0, 1, 0, 0);
    // The request was consumed, so the next cycle skips PED
    add_plain_cycle();
    // Run to LEFT_G at timer 6 with a pedestrian request latched
    add(MAIN_G, 1, 7, 0, 1, 0, 0);
    add(MAIN_Y, 0, 2, 0, 1, 0, 0);
    add(ALL_RED, 0, 0, 0, 0, 0, 0);
    add(LEFT_G, 0, 2, 0, 0, 0, 0);
    add(LEFT_G, 3, 6, 0, 0, 0, 0, 1'b1);
    run_vectors("seq");

    // Asynchronous reset between edges, with tick low
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 compare_outputs("async_rst", rst_e);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    compare_outputs("idle50", rst_e);

    // Restart from ALL_RED. The cleared request means no PED this cycle.
    add(MAIN_G, 0, 0, 0, 1, 0, 0);
    add_plain_cycle();
    run_vectors("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_controller.md
# phase_controller

Traffic-light phase sequencer that consumes the lane-comparison flags (`m_more`, `l_zero`, `s_more`, `p_more`) and drives the main, left-turn, secondary and pedestrian signal heads. It sits downstream of the lane comparator and is the only block that owns light state. It is a tick-driven Moore FSM with a per-phase duration timer and a latched pedestrian request.

## Interface
- `GREEN_MIN`, default 8: minimum green duration, in ticks.
- `GREEN_MAX`, default 20: maximum (extended) green duration, in ticks.
- `YELLOW`, default 3: yellow duration, in ticks.
- `PED_WALK`, default 10: pedestrian walk duration, in ticks.
- `CNT_W`, default 5: timer width. Requires 1 ≤ `GREEN_MIN` ≤ `GREEN_MAX` < 2^`CNT_W`, `YELLOW` ≥ 1, `PED_WALK` ≥ 1, all < 2^`CNT_W`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle time-base enable. Nothing advances without it.
- `m_more` in 1: main queue exceeds twice the left queue.
- `l_zero` in 1: left queue empty.
- `s_more` in 1: secondary queue equals main queue.
- `p_more` in 1: pedestrian count exceeds main plus secondary.
- `main_light` out 3: {red, yellow, green}, one-hot.
- `left_light` out 3: {red, yellow, green}, one-hot.
- `sec_light` out 3: {red, yellow, green}, one-hot.
- `ped_walk` out 1: walk indication.
- `phase` out 3: current state encoding.
- `timer` out `CNT_W`: ticks completed in the current state.

## Operation
- State encoding (`phase`):
  - 0 `MAIN_G`
  - 1 `MAIN_Y`
  - 2 `LEFT_G`
  - 3 `LEFT_Y`
  - 4 `SEC_G`
  - 5 `SEC_Y`
  - 6 `PED`
  - 7 `ALL_RED`
- Lights decode combinationally from the state register (Moore outputs).
  - `*_G` states: that head is 3'b001; all other heads are 3'b100.
  - `*_Y` states: that head is 3'b010; all other heads are 3'b100.
  - `PED` and `ALL_RED`: all heads are 3'b100.
  - `ped_walk` = 1 only in `PED`.
- Timer behaviour on a cycle with `tick`=1:
  - If `timer`+1 meets the exit condition of the current state, the state changes and `timer` ← 0.
  - Otherwise `timer` ← `timer`+1.
  - With `tick`=0, state and timer hold.
- Exit conditions, evaluated with n = `timer`+1 and flags sampled on the exit-tick cycle:
  - `MAIN_G`: (n ≥ `GREEN_MIN` and !`m_more`) or n = `GREEN_MAX`. Goes to `MAIN_Y`.
  - `LEFT_G`: (n ≥ `GREEN_MIN` and `l_zero`) or n = `GREEN_MAX`. Goes to `LEFT_Y`.
  - `SEC_G`: (n ≥ `GREEN_MIN` and !`s_more`) or n = `GREEN_MAX`. Goes to `SEC_Y`.
  - Any `*_Y`: n = `YELLOW`. Goes to `ALL_RED`. The target is latched into `next_ph` at this moment:
    - from `MAIN_Y`: `LEFT_G` if !`l_zero`, else `SEC_G`;
    - from `LEFT_Y`: `SEC_G`;
    - from `SEC_Y`: `PED` if (`ped_pending` | `p_more`), else `MAIN_G`.
  - `PED`: n = `PED_WALK`. Goes to `ALL_RED` with `next_ph` = `MAIN_G`.
  - `ALL_RED`: n = 1. Goes to `next_ph`.
- `ped_pending`:
  - Set on any cycle with `p_more`=1 while the state is not `PED`.
  - Cleared on the edge that enters `PED`. Clear wins over a simultaneous set.
- Reset values:
  - state `ALL_RED`, `next_ph` = `MAIN_G`, `timer` = 0, `ped_pending` = 0.
  - Outputs: all heads 3'b100, `ped_walk` = 0, `phase` = 7.
- Reset mid-operation: all outputs immediately go all-red. The cycle restarts from `ALL_RED` → `MAIN_G`.
- The timer never wraps: every state exits at or before its bound, and `GREEN_MAX` < 2^`CNT_W`.

## Timing
- State and `timer` change only on a rising edge where `tick`=1. Outputs are valid in the same cycle the new state is registered.
- Latency from the exit tick to the light change is one edge. There are no combinational paths from flags to lights.
- Exact durations, in ticks:
  - green: `GREEN_MIN` to `GREEN_MAX`;
  - yellow: `YELLOW`;
  - all-red: 1;
  - walk: `PED_WALK`.
- Flags are don't-care except on tick cycles, with one exception: `p_more` is sampled every cycle for `ped_pending`.
- `tick` asserted on consecutive cycles is legal. Each assertion counts as one tick.

## Test plan
- Reset then one tick: `phase`=7 with all heads 3'b100 during reset. After the first tick, `phase`=0, `main_light`=3'b001, `timer`=0.
- `m_more`=0, `l_zero`=1, `s_more`=0, `p_more`=0, defaults: `MAIN_G` lasts 8 ticks, `MAIN_Y` 3, `ALL_RED` 1, then `SEC_G` 8, `SEC_Y` 3, `ALL_RED` 1, back to `MAIN_G`. The full cycle is 24 ticks.
- `m_more`=1 held: `MAIN_G` lasts exactly 20 ticks. Dropping `m_more` at tick 12 exits on tick 12.
- `l_zero`=0 at the `MAIN_Y` exit tick → `ALL_RED` → `LEFT_G` (`left_light`=3'b001, `main_light`=3'b100). Raising `l_zero` at tick 5 still holds green until tick 8. With `l_zero` held at 0, green lasts 20.
- `p_more` pulsed for one non-tick cycle during `MAIN_G` → after `SEC_Y` and `ALL_RED`, `PED` with `ped_walk`=1 for 10 ticks, then `ALL_RED` → `MAIN_G`. `ped_pending`=0 afterwards, and the next cycle skips `PED`.
- `rst_n` pulsed low during `LEFT_G` at `timer`=6 with `tick`=0 → asynchronous all-red, `timer`=0, `ped_pending`=0. With `tick` held at 0 for 50 cycles after release, `phase` stays 7.
